// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive/transmit layers.
//  state_t          : receive FSM states
//  UDP_HDR_LEN      : UDP header size in bytes
//  UDP_MIN_PAYLOAD  : smallest payload that needs no Ethernet padding (shared with TX)
package udp_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT,
    HD00,
    HD01,
    HD02,
    HD03,
    HD04,
    HD05,
    HD06,
    HD07,
    WORK,
    DROP,
    DONE
  } state_t;

  localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
  localparam logic [15:0] UDP_MIN_PAYLOAD = 16'd18;

endpackage

// File: rtl/udp_rx.sv
// Receive-side UDP layer. Parses the 8-byte UDP header from the IP byte
// stream, filters on destination port, forwards payload bytes to the
// downstream FIFO and reports completion via the fs/fd level handshake.
// Checksum is not verified.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  fs / fd             frame start (from IP) / frame done (to IP, held until fs drops)
//  rxd_vld, rxd        incoming datagram bytes, MSB byte of each field first
//  local_port          port this node listens on
//  src_port, det_port  ports of the last accepted datagram
//  data_len            payload length of the last accepted datagram
//  fifo_txen, fifo_txd payload FIFO write strobe/data (1-cycle latency)
//  err_len, err_port, err_abort  per-datagram sticky error flags
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter logic [15:0] MAX_LEN  = 16'd1472,
  parameter int          CHK_PORT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic        rxd_vld,
  input  logic [7:0]  rxd,
  input  logic [15:0] local_port,
  output logic [15:0] src_port,
  output logic [15:0] det_port,
  output logic [15:0] data_len,
  output logic        fifo_txen,
  output logic [7:0]  fifo_txd,
  output logic        err_len,
  output logic        err_port,
  output logic        err_abort
);

  state_t      state, next;
  logic [15:0] src_sh, dst_sh, plen, cnt;
  logic [7:0]  len_hi;
  logic [15:0] udp_len, pay_len;
  logic        last, in_frame;

  assign udp_len  = {len_hi, rxd};
  assign pay_len  = udp_len - UDP_HDR_LEN;
  assign last     = (cnt == plen - 16'd1);
  assign in_frame = (state inside {[HD00:HD07], WORK, DROP});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    fd   = 1'b0;
    case (state)
      IDLE: next = WAIT;
      WAIT: if (fs) next = HD00;
      HD00, HD01, HD02, HD03, HD04, HD05, HD06: begin
        if (!fs)          next = WAIT;
        else if (rxd_vld) next = state_t'(state + 4'd1);
      end
      HD07: begin
        if (!fs) next = WAIT;
        else if (rxd_vld) begin
          if (err_len || err_port) next = DROP;
          else if (plen == '0)     next = DONE;
          else                     next = WORK;
        end
      end
      WORK: begin
        if (!fs)                  next = WAIT;
        else if (rxd_vld && last) next = DONE;
      end
      // plen is forced to 0 for a runt udp_len, so DROP leaves without consuming bytes
      DROP: begin
        if (!fs)                  next = WAIT;
        else if (plen == '0)      next = DONE;
        else if (rxd_vld && last) next = DONE;
      end
      DONE: begin
        fd = 1'b1;
        if (!fs) next = WAIT;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_sh    <= '0;
      dst_sh    <= '0;
      len_hi    <= '0;
      plen      <= '0;
      cnt       <= '0;
      src_port  <= '0;
      det_port  <= '0;
      data_len  <= '0;
      fifo_txen <= 1'b0;
      fifo_txd  <= '0;
      err_len   <= 1'b0;
      err_port  <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      fifo_txen <= (state == WORK) && fs && rxd_vld;
      if ((state == WORK) && fs && rxd_vld) fifo_txd <= rxd;

      if (state == WORK || state == DROP) cnt <= cnt + {15'd0, rxd_vld};
      else                                cnt <= '0;

      if (state == WAIT && fs) begin
        err_len   <= 1'b0;
        err_port  <= 1'b0;
        err_abort <= 1'b0;
      end
      if (in_frame && !fs) err_abort <= 1'b1;

      if (fs && rxd_vld) begin
        case (state)
          HD00: src_sh[15:8] <= rxd;
          HD01: src_sh[7:0]  <= rxd;
          HD02: dst_sh[15:8] <= rxd;
          HD03: begin
            dst_sh[7:0] <= rxd;
            if ((CHK_PORT != 0) && ({dst_sh[15:8], rxd} != local_port)) err_port <= 1'b1;
          end
          HD04: len_hi <= rxd;
          HD05: begin
            if (udp_len < UDP_HDR_LEN) begin
              err_len <= 1'b1;
              plen    <= '0;
            end else begin
              plen <= pay_len;
              if (pay_len > MAX_LEN) err_len <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Published fields change only for datagrams that were actually delivered
      if (next == DONE && (state == WORK || state == HD07)) begin
        src_port <= src_sh;
        det_port <= dst_sh;
        data_len <= plen;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
module tb_udp_rx;
  logic        clk = 1'b0;
  logic        rst, fs, fd, rxd_vld;
  logic [7:0]  rxd;
  logic [15:0] local_port, src_port, det_port, data_len;
  logic        fifo_txen;
  logic [7:0]  fifo_txd;
  logic        err_len, err_port, err_abort;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];

  udp_rx #(.MAX_LEN(16'd1472), .CHK_PORT(1)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .rxd_vld(rxd_vld), .rxd(rxd),
    .local_port(local_port), .src_port(src_port), .det_port(det_port),
    .data_len(data_len), .fifo_txen(fifo_txen), .fifo_txd(fifo_txd),
    .err_len(err_len), .err_port(err_port), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && fifo_txen) got.push_back(fifo_txd);

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    @(negedge clk);
    rxd_vld = 1'b1;
    rxd     = b;
    if (gap) begin
      @(negedge clk);
      rxd_vld = 1'b0;
      rxd     = 8'h5A;
    end
  endtask

  task automatic send_hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input bit gap);
    logic [15:0] c;
    c = 16'h0000;
    @(negedge clk);
    fs = 1'b1;
    send_byte(s[15:8], gap); send_byte(s[7:0], gap);
    send_byte(d[15:8], gap); send_byte(d[7:0], gap);
    send_byte(l[15:8], gap); send_byte(l[7:0], gap);
    send_byte(c[15:8], gap); send_byte(c[7:0], gap);
  endtask

  task automatic send_payload(input logic [7:0] base, input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), gap);
  endtask

  task automatic end_bytes();
    @(negedge clk);
    rxd_vld = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    for (int i = 0; i < 8 && fd !== 1'b1; i++) @(negedge clk);
    check(tag, fd, 1'b1);
  endtask

  task automatic drop_fs(input string tag);
    @(negedge clk);
    fs = 1'b0;
    @(negedge clk);
    check(tag, fd, 1'b0);
  endtask

  task automatic check_payload(input string tag, input logic [7:0] base, input int n);
    check(tag, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(tag, got[i], base + 8'(i));
    got.delete();
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; rxd_vld = 1'b0; rxd = 8'h00; local_port = 16'h1388;
    #1;
    check("rst_fd", fd, 1'b0);
    check("rst_txen", fifo_txen, 1'b0);
    check("rst_src", src_port, 16'h0);
    check("rst_dst", det_port, 16'h0);
    check("rst_len", data_len, 16'h0);
    check("rst_errs", {err_len, err_port, err_abort}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: nominal 20-byte payload
    send_hdr(16'h1F90, 16'h1388, 16'h001C, 1'b0);
    send_payload(8'h00, 20, 1'b0);
    end_bytes();
    wait_fd("t1_fd");
    repeat (3) @(negedge clk);
    check("t1_fd_held", fd, 1'b1);
    check("t1_len", data_len, 16'd20);
    check("t1_src", src_port, 16'h1F90);
    check("t1_dst", det_port, 16'h1388);
    check("t1_errs", {err_len, err_port, err_abort}, 3'b000);
    drop_fs("t1_fd_low");
    check_payload("t1_data", 8'h00, 20);

    // 2: 18-byte payload followed by Ethernet pad
    send_hdr(16'h1234, 16'h1388, 16'h001A, 1'b0);
    send_payload(8'hA0, 18, 1'b0);
    send_payload(8'hEE, 4, 1'b0);
    end_bytes();
    wait_fd("t2_fd");
    check("t2_len", data_len, 16'd18);
    check("t2_src", src_port, 16'h1234);
    drop_fs("t2_fd_low");
    check_payload("t2_data", 8'hA0, 18);

    // 3: destination port mismatch
    send_hdr(16'h5555, 16'h1389, 16'h0010, 1'b0);
    send_payload(8'h30, 8, 1'b0);
    end_bytes();
    wait_fd("t3_fd");
    check("t3_err_port", err_port, 1'b1);
    check("t3_src", src_port, 16'h1234);
    check("t3_dst", det_port, 16'h1388);
    check("t3_len", data_len, 16'd18);
    drop_fs("t3_fd_low");
    check_payload("t3_data", 8'h00, 0);

    // 4a: runt udp_len
    send_hdr(16'h0001, 16'h1388, 16'h0004, 1'b0);
    end_bytes();
    wait_fd("t4a_fd");
    check("t4a_errs", {err_len, err_port, err_abort}, 3'b100);
    check("t4a_len", data_len, 16'd18);
    drop_fs("t4a_fd_low");
    check_payload("t4a_data", 8'h00, 0);

    // 4b: header-only datagram
    send_hdr(16'h0A0B, 16'h1388, 16'h0008, 1'b0);
    end_bytes();
    wait_fd("t4b_fd");
    check("t4b_errs", {err_len, err_port, err_abort}, 3'b000);
    check("t4b_len", data_len, 16'd0);
    check("t4b_src", src_port, 16'h0A0B);
    drop_fs("t4b_fd_low");
    check_payload("t4b_data", 8'h00, 0);

    // 5: case 1 with rxd_vld gaps everywhere
    send_hdr(16'h1F90, 16'h1388, 16'h001C, 1'b1);
    send_payload(8'h00, 20, 1'b1);
    end_bytes();
    wait_fd("t5_fd");
    check("t5_len", data_len, 16'd20);
    check("t5_src", src_port, 16'h1F90);
    check("t5_errs", {err_len, err_port, err_abort}, 3'b000);
    drop_fs("t5_fd_low");
    check_payload("t5_data", 8'h00, 20);

    // 6a: fs drops after 5 payload bytes
    send_hdr(16'h2222, 16'h1388, 16'h001C, 1'b0);
    send_payload(8'h40, 5, 1'b0);
    @(negedge clk);
    rxd_vld = 1'b0;
    fs      = 1'b0;
    @(negedge clk);
    check("t6_abort", err_abort, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_fd", fd, 1'b0);
    check("t6_len", data_len, 16'd20);
    check("t6_src", src_port, 16'h1F90);
    check_payload("t6_data", 8'h40, 5);

    // 6b: asynchronous reset in the middle of WORK
    send_hdr(16'h3333, 16'h1388, 16'h001C, 1'b0);
    send_payload(8'h50, 3, 1'b0);
    @(negedge clk);
    check("t6b_txen_pre", fifo_txen, 1'b1);
    rst = 1'b1;
    #1;
    check("t6b_txen", fifo_txen, 1'b0);
    check("t6b_fd", fd, 1'b0);
    check("t6b_src", src_port, 16'h0);
    check("t6b_len", data_len, 16'h0);
    check("t6b_errs", {err_len, err_port, err_abort}, 3'b000);
    rxd_vld = 1'b0;
    fs      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
